regfile_wb_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: A (ALU/execute) and B (load/multicycle unit).
- Each requester has a small in-order FIFO. One entry per cycle is arbitrated onto a registered write port that drives the register file's w_en/w_addr/w_din.
- Also exports a pending-write mask for hazard detection in decode.

---
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle for the two writeback request channels, the registered register-file
// write port and the status outputs of regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic               a_valid;
    logic               a_ready;
    logic [AW-1:0]      a_addr;
    logic [DW-1:0]      a_data;
    logic               b_valid;
    logic               b_ready;
    logic [AW-1:0]      b_addr;
    logic [DW-1:0]      b_data;
    logic               w_en;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_din;
    logic [(2**AW)-1:0] pend_mask;
    logic [LW-1:0]      a_level;
    logic [LW-1:0]      b_level;
    logic [15:0]        zero_drops;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, w_en, w_addr, w_din, pend_mask,
               a_level, b_level, zero_drops
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, w_en, w_addr, w_din, pend_mask,
               a_level, b_level, zero_drops
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter onto one registered register-file write port.
// Define REGFILE_WB_ARB_RR_EN for round-robin; default is fixed A-over-B priority.
module regfile_wb_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int NREG = 2**AW;

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]                       w_valid, w_ready, w_push, w_zero, w_pop, w_nempty;
    logic [1:0][AW-1:0]               w_in_addr;
    logic [1:0][DW-1:0]               w_in_data;
    logic [1:0][DEPTH-1:0][AW-1:0]    r_addr;
    logic [1:0][DEPTH-1:0][DW-1:0]    r_data;
    logic [1:0][PW-1:0]               r_rd, r_wr;
    logic [1:0][LW-1:0]               r_level;
    logic                             r_wen;
    logic [AW-1:0]                    r_waddr;
    logic [DW-1:0]                    r_wdin;
    logic [15:0]                      r_zero;
    logic [16:0]                      w_zsum;
    logic                             w_sel;
    logic [NREG-1:0]                  w_pend;
`ifdef REGFILE_WB_ARB_RR_EN
    logic                             r_last_a;
`endif

    assign w_valid   = {bus.b_valid, bus.a_valid};
    assign w_in_addr = {bus.b_addr, bus.a_addr};
    assign w_in_data = {bus.b_data, bus.a_data};

    for (genvar g = 0; g < 2; g++) begin : g_req
        assign w_ready[g]  = r_level[g] != LW'(DEPTH);
        assign w_nempty[g] = r_level[g] != '0;
        // Writes to register 0 are accepted but never queued.
        assign w_zero[g]   = w_valid[g] && w_ready[g] && (w_in_addr[g] == '0);
        assign w_push[g]   = w_valid[g] && w_ready[g] && (w_in_addr[g] != '0);
    end

    always_comb begin
        w_pop = '0;
`ifdef REGFILE_WB_ARB_RR_EN
        if (w_nempty[0] && w_nempty[1]) w_pop = r_last_a ? 2'b10 : 2'b01;
        else if (w_nempty[0])           w_pop = 2'b01;
        else if (w_nempty[1])           w_pop = 2'b10;
`else
        if (w_nempty[0])      w_pop = 2'b01;
        else if (w_nempty[1]) w_pop = 2'b10;
`endif
    end

    assign w_sel  = w_pop[1];
    assign w_zsum = {1'b0, r_zero} + 17'(w_zero[0]) + 17'(w_zero[1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdin  <= '0;
            r_zero  <= '0;
`ifdef REGFILE_WB_ARB_RR_EN
            r_last_a <= 1'b0;
`endif
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (w_push[g]) begin
                    r_addr[g][r_wr[g]] <= w_in_addr[g];
                    r_data[g][r_wr[g]] <= w_in_data[g];
                    r_wr[g]            <= r_wr[g] + 1'b1;
                end
                if (w_pop[g]) r_rd[g] <= r_rd[g] + 1'b1;
                r_level[g] <= r_level[g] + LW'(w_push[g]) - LW'(w_pop[g]);
            end
            r_wen <= |w_pop;
            if (|w_pop) begin
                r_waddr <= r_addr[w_sel][r_rd[w_sel]];
                r_wdin  <= r_data[w_sel][r_rd[w_sel]];
`ifdef REGFILE_WB_ARB_RR_EN
                r_last_a <= w_pop[0];
`endif
            end
            r_zero <= w_zsum[16] ? 16'hFFFF : w_zsum[15:0];
        end
    end

    // Live FIFO entries are the LEVEL slots starting at the read pointer.
    always_comb begin
        w_pend = '0;
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < DEPTH; k++)
                if (LW'(k) < r_level[g])
                    w_pend[r_addr[g][r_rd[g] + PW'(k)]] = 1'b1;
        if (r_wen) w_pend[r_waddr] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign bus.a_ready    = w_ready[0];
    assign bus.b_ready    = w_ready[1];
    assign bus.w_en       = r_wen;
    assign bus.w_addr     = r_waddr;
    assign bus.w_din      = r_wdin;
    assign bus.pend_mask  = w_pend;
    assign bus.a_level    = r_level[0];
    assign bus.b_level    = r_level[1];
    assign bus.zero_drops = r_zero;
endmodule
